// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the load/store memory access controller:
// Alpha memory opcodes, exception codes and the controller state encoding.
package mem_access_ctrl_pkg;

    localparam logic [5:0] OPC_LDQ_U = 6'h0B;
    localparam logic [5:0] OPC_STQ_U = 6'h0F;
    localparam logic [5:0] OPC_LDL   = 6'h28;
    localparam logic [5:0] OPC_LDQ   = 6'h29;
    localparam logic [5:0] OPC_STL   = 6'h2C;
    localparam logic [5:0] OPC_STQ   = 6'h2D;

    localparam logic [1:0] EXC_ALIGN = 2'b01;
    localparam logic [1:0] EXC_BUS   = 2'b10;
    localparam logic [1:0] EXC_TMO   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BEAT0,
        ST_BEAT1,
        ST_WB,
        ST_FAULT
    } state_t;

    // The _U quad forms ignore the low three address bits instead of faulting.
    function automatic logic is_u_form(input logic [5:0] opc);
        return (opc == OPC_LDQ_U) || (opc == OPC_STQ_U);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_align.sv
// Opcode decode and alignment check for the memory access controller.
module mem_align_chk
    import mem_access_ctrl_pkg::*;
(
    input  logic [5:0] opc,
    input  logic [2:0] adr_lo,
    output logic       is_mem,
    output logic       is_load,
    output logic       is_quad,
    output logic       misaligned
);

    always_comb begin
        is_mem     = 1'b0;
        is_load    = 1'b0;
        is_quad    = 1'b0;
        misaligned = 1'b0;
        case (opc)
            OPC_LDL: begin
                is_mem     = 1'b1;
                is_load    = 1'b1;
                misaligned = |adr_lo[1:0];
            end
            OPC_STL: begin
                is_mem     = 1'b1;
                misaligned = |adr_lo[1:0];
            end
            OPC_LDQ: begin
                is_mem     = 1'b1;
                is_load    = 1'b1;
                is_quad    = 1'b1;
                misaligned = |adr_lo;
            end
            OPC_STQ: begin
                is_mem     = 1'b1;
                is_quad    = 1'b1;
                misaligned = |adr_lo;
            end
            OPC_LDQ_U: begin
                is_mem  = 1'b1;
                is_load = 1'b1;
                is_quad = 1'b1;
            end
            OPC_STQ_U: begin
                is_mem  = 1'b1;
                is_quad = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: splits quads into two 32-bit req/ack beats, guards each
// beat with a watchdog, and returns load data or an exception strobe.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int ADR_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_opc,
    input  logic [63:0]      in_adr,
    input  logic [63:0]      in_data,
    input  logic [4:0]       in_dest,
    output logic             mem_req,
    output logic             mem_we,
    output logic [ADR_W-1:0] mem_adr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ack,
    input  logic             mem_err,
    input  logic [31:0]      mem_rdata,
    output logic             wb_valid,
    output logic [4:0]       wb_dest,
    output logic [63:0]      wb_data,
    output logic             exc_valid,
    output logic [1:0]       exc_code
);

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       exc_q;
    logic [1:0]       exc_nxt;
    logic [ADR_W-1:0] adr_q;
    logic [63:0]      data_q;
    logic [4:0]       dest_q;
    logic             load_q;
    logic             quad_q;
    logic [31:0]      lo_q;
    logic [63:0]      wbd_q;
    logic [7:0]       wdog;

    logic             chk_mem;
    logic             chk_load;
    logic             chk_quad;
    logic             chk_mis;
    logic             accept;
    logic             in_beat;
    logic             tmo;
    logic [ADR_W-1:0] adr_in;
    logic             unused_adr_hi;

    assign adr_in        = in_adr[ADR_W-1:0];
    assign unused_adr_hi = ^in_adr[63:ADR_W];
    assign accept        = in_valid && (state == ST_IDLE);
    assign in_beat       = (state == ST_BEAT0) || (state == ST_BEAT1);
    assign tmo           = in_beat && (wdog == TMO_LIMIT);

    mem_align_chk u_align (
        .opc        (in_opc),
        .adr_lo     (in_adr[2:0]),
        .is_mem     (chk_mem),
        .is_load    (chk_load),
        .is_quad    (chk_quad),
        .misaligned (chk_mis)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            exc_q <= 2'b00;
        end else begin
            state <= state_nxt;
            exc_q <= exc_nxt;
        end
    end

    // An ack sampled in the same cycle as the watchdog limit still completes the beat.
    always_comb begin
        state_nxt = state;
        exc_nxt   = exc_q;
        case (state)
            ST_IDLE: begin
                if (accept && chk_mem) begin
                    if (chk_mis) begin
                        state_nxt = ST_FAULT;
                        exc_nxt   = EXC_ALIGN;
                    end else begin
                        state_nxt = ST_BEAT0;
                    end
                end
            end
            ST_BEAT0, ST_BEAT1: begin
                if (mem_ack) begin
                    if (mem_err) begin
                        state_nxt = ST_FAULT;
                        exc_nxt   = EXC_BUS;
                    end else if ((state == ST_BEAT0) && quad_q) begin
                        state_nxt = ST_BEAT1;
                    end else if (load_q) begin
                        state_nxt = ST_WB;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (tmo) begin
                    state_nxt = ST_FAULT;
                    exc_nxt   = EXC_TMO;
                end
            end
            ST_WB, ST_FAULT: state_nxt = ST_IDLE;
            default:         state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_q  <= '0;
            data_q <= '0;
            dest_q <= '0;
            load_q <= 1'b0;
            quad_q <= 1'b0;
            lo_q   <= '0;
            wbd_q  <= '0;
            wdog   <= '0;
        end else begin
            if (accept) begin
                adr_q  <= is_u_form(in_opc) ? (adr_in & ~ADR_W'(7)) : adr_in;
                data_q <= in_data;
                dest_q <= in_dest;
                load_q <= chk_load;
                quad_q <= chk_quad;
            end
            // The watchdog restarts from zero whenever a beat is acked or left.
            if (in_beat && !mem_ack && !tmo) begin
                wdog <= wdog + 8'd1;
            end else begin
                wdog <= '0;
            end
            if ((state == ST_BEAT0) && mem_ack) begin
                lo_q <= mem_rdata;
            end
            if (mem_ack && !mem_err && load_q) begin
                if ((state == ST_BEAT0) && !quad_q) begin
                    wbd_q <= {{32{mem_rdata[31]}}, mem_rdata};
                end else if (state == ST_BEAT1) begin
                    wbd_q <= {mem_rdata, lo_q};
                end
            end
        end
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        mem_req   = in_beat && !tmo;
        mem_we    = in_beat && !load_q;
        mem_adr   = '0;
        mem_wdata = '0;
        if (state == ST_BEAT0) begin
            mem_adr = adr_q;
        end else if (state == ST_BEAT1) begin
            mem_adr = adr_q + ADR_W'(4);
        end
        if (in_beat && !load_q) begin
            mem_wdata = (state == ST_BEAT1) ? data_q[63:32] : data_q[31:0];
        end
        wb_valid  = (state == ST_WB);
        wb_dest   = (state == ST_WB) ? dest_q : 5'd0;
        wb_data   = (state == ST_WB) ? wbd_q : 64'd0;
        exc_valid = (state == ST_FAULT);
        exc_code  = (state == ST_FAULT) ? exc_q : 2'b00;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a transaction-level model predicts
// every cycle's outputs; literal checks pin the model on the directed cases.
module tb_mem_access_ctrl;

    localparam int TMO = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opc;
    logic [63:0] in_adr;
    logic [63:0] in_data;
    logic [4:0]  in_dest;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        mem_err;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic [63:0] wb_data;
    logic        exc_valid;
    logic [1:0]  exc_code;

    logic        exp_in_ready;
    logic        exp_req;
    logic        exp_we;
    logic [31:0] exp_adr;
    logic [31:0] exp_wdata;
    logic        exp_wb_valid;
    logic [4:0]  exp_wb_dest;
    logic [63:0] exp_wb_data;
    logic        exp_exc_valid;
    logic [1:0]  exp_exc_code;
    logic        check_en;

    int          checks;
    int          passed;
    logic [31:0] obs_adr[$];
    logic [31:0] obs_wdata[$];
    logic [63:0] last_wb;

    mem_access_ctrl #(.TIMEOUT(TMO), .ADR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opc    (in_opc),
        .in_adr    (in_adr),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_err   (mem_err),
        .mem_rdata (mem_rdata),
        .wb_valid  (wb_valid),
        .wb_dest   (wb_dest),
        .wb_data   (wb_data),
        .exc_valid (exc_valid),
        .exc_code  (exc_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic set_idle_exp();
        exp_in_ready  = 1'b1;
        exp_req       = 1'b0;
        exp_we        = 1'b0;
        exp_adr       = '0;
        exp_wdata     = '0;
        exp_wb_valid  = 1'b0;
        exp_wb_dest   = '0;
        exp_wb_data   = '0;
        exp_exc_valid = 1'b0;
        exp_exc_code  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison against the model; bus fields only matter while requesting.
    always @(negedge clk) begin
        if (check_en) begin
            check_output("in_ready", in_ready, exp_in_ready);
            check_output("mem_req", mem_req, exp_req);
            if (exp_req) begin
                check_output("mem_adr", mem_adr, exp_adr);
                check_output("mem_we", mem_we, exp_we);
                if (exp_we) check_output("mem_wdata", mem_wdata, exp_wdata);
            end
            check_output("wb_valid", wb_valid, exp_wb_valid);
            if (exp_wb_valid) begin
                check_output("wb_dest", wb_dest, exp_wb_dest);
                check_output("wb_data", wb_data, exp_wb_data);
            end
            check_output("exc_valid", exc_valid, exp_exc_valid);
            if (exp_exc_valid) check_output("exc_code", exc_code, exp_exc_code);
            if (mem_req && mem_ack) begin
                obs_adr.push_back(mem_adr);
                obs_wdata.push_back(mem_wdata);
            end
            if (wb_valid) last_wb = wb_data;
        end
    end

    // Issues one operation and walks the model through it cycle by cycle.
    // dly[b] is the cycle within beat b on which ack arrives (> TMO means never).
    task automatic apply_stimulus(input logic [5:0] opc, input logic [63:0] adr, input logic [63:0] data,
                                  input logic [4:0] dest, input int d0, input int d1,
                                  input logic [31:0] r0, input logic [31:0] r1, input int err_beat);
        logic        is_mem, load, quad, ufm, misal, stop, ack;
        logic [31:0] base;
        logic [31:0] rd[2];
        int          dly[2];
        int          outcome;
        int          nb;
        obs_adr.delete();
        obs_wdata.delete();
        last_wb = '0;
        dly[0] = d0;
        dly[1] = d1;
        rd[0]  = r0;
        rd[1]  = r1;

        set_idle_exp();
        in_valid = 1'b1;
        in_opc   = opc;
        in_adr   = adr;
        in_data  = data;
        in_dest  = dest;
        step();
        in_valid = 1'b0;

        is_mem = opc inside {6'h28, 6'h29, 6'h0B, 6'h2C, 6'h2D, 6'h0F};
        load   = opc inside {6'h28, 6'h29, 6'h0B};
        quad   = opc inside {6'h29, 6'h0B, 6'h2D, 6'h0F};
        ufm    = opc inside {6'h0B, 6'h0F};
        misal  = !ufm && (quad ? (adr % 8 != 0) : (adr % 4 != 0));
        base   = ufm ? (adr[31:0] / 8) * 8 : adr[31:0];
        nb     = quad ? 2 : 1;
        outcome = 0;

        if (is_mem && misal) begin
            set_idle_exp();
            exp_in_ready  = 1'b0;
            exp_exc_valid = 1'b1;
            exp_exc_code  = 2'd1;
            step();
        end else if (is_mem) begin
            stop = 1'b0;
            for (int b = 0; b < nb && !stop; b++) begin
                for (int k = 0; k <= TMO && !stop; k++) begin
                    set_idle_exp();
                    exp_in_ready = 1'b0;
                    exp_req      = (k < TMO);
                    exp_we       = !load;
                    exp_adr      = base + 32'(4 * b);
                    exp_wdata    = (b == 0) ? data[31:0] : data[63:32];
                    ack          = (k == dly[b]);
                    mem_ack      = ack;
                    mem_err      = ack && (err_beat == b);
                    mem_rdata    = rd[b];
                    step();
                    mem_ack = 1'b0;
                    mem_err = 1'b0;
                    if (ack) begin
                        if (err_beat == b) begin
                            outcome = 2;
                            stop    = 1'b1;
                        end
                        break;
                    end else if (k == TMO) begin
                        outcome = 3;
                        stop    = 1'b1;
                    end
                end
            end
            set_idle_exp();
            exp_in_ready = 1'b0;
            if (outcome != 0) begin
                exp_exc_valid = 1'b1;
                exp_exc_code  = 2'(outcome);
                step();
            end else if (load) begin
                exp_wb_valid = 1'b1;
                exp_wb_dest  = dest;
                exp_wb_data  = quad ? {r1, r0} : {{32{r0[31]}}, r0};
                step();
            end
        end
        set_idle_exp();
        step();
    endtask

    initial begin
        checks    = 0;
        passed    = 0;
        check_en  = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_opc    = '0;
        in_adr    = '0;
        in_data   = '0;
        in_dest   = '0;
        mem_ack   = 1'b0;
        mem_err   = 1'b0;
        mem_rdata = '0;
        last_wb   = '0;
        set_idle_exp();
        #3;
        check_output("reset in_ready", in_ready, 1'b1);
        check_output("reset mem_req", mem_req, 1'b0);
        check_output("reset mem_adr", mem_adr, 32'd0);
        check_output("reset wb_valid", wb_valid, 1'b0);
        check_output("reset wb_data", wb_data, 64'd0);
        check_output("reset exc_valid", exc_valid, 1'b0);
        check_en = 1'b1;
        step();
        rst_n = 1'b1;
        step();

        apply_stimulus(6'h28, 64'h1000, 64'h0, 5'd7, 0, 0, 32'h80000001, 32'h0, -1);
        check_output("ldl beat adr", (obs_adr.size() == 1) ? obs_adr[0] : 32'hDEAD, 32'h1000);
        check_output("ldl wb literal", last_wb, 64'hFFFFFFFF80000001);

        apply_stimulus(6'h2D, 64'h2008, 64'h11223344_55667788, 5'd0, 3, 3, 32'h0, 32'h0, -1);
        check_output("stq beats", obs_adr.size(), 64'd2);
        if (obs_adr.size() == 2) begin
            check_output("stq beat0 adr", obs_adr[0], 32'h2008);
            check_output("stq beat0 data", obs_wdata[0], 32'h55667788);
            check_output("stq beat1 adr", obs_adr[1], 32'h200C);
            check_output("stq beat1 data", obs_wdata[1], 32'h11223344);
        end
        check_output("stq no wb", last_wb, 64'd0);

        apply_stimulus(6'h29, 64'h3004, 64'h0, 5'd3, 0, 0, 32'h0, 32'h0, -1);
        check_output("ldq align no bus", obs_adr.size(), 64'd0);

        apply_stimulus(6'h0B, 64'h3007, 64'h0, 5'd9, 1, 0, 32'hAABBCCDD, 32'h01020304, -1);
        check_output("ldq_u beats", obs_adr.size(), 64'd2);
        if (obs_adr.size() == 2) begin
            check_output("ldq_u beat0 adr", obs_adr[0], 32'h3000);
            check_output("ldq_u beat1 adr", obs_adr[1], 32'h3004);
        end
        check_output("ldq_u wb literal", last_wb, 64'h01020304_AABBCCDD);

        apply_stimulus(6'h29, 64'h4000, 64'h0, 5'd1, 0, 0, 32'h1, 32'h2, 0);
        check_output("ldq err one beat", obs_adr.size(), 64'd1);
        apply_stimulus(6'h29, 64'h4000, 64'h0, 5'd1, 99, 0, 32'h1, 32'h2, -1);
        apply_stimulus(6'h29, 64'h6000, 64'h0, 5'd2, 0, 99, 32'h5, 32'h6, -1);
        apply_stimulus(6'h2C, 64'h5000, 64'hFFFF0000_CAFEF00D, 5'd0, TMO, 0, 32'h0, 32'h0, -1);
        apply_stimulus(6'h2C, 64'h2002, 64'h0, 5'd0, 0, 0, 32'h0, 32'h0, -1);
        apply_stimulus(6'h28, 64'h1004, 64'h0, 5'd31, 2, 0, 32'h7FFFFFFF, 32'h0, -1);
        apply_stimulus(6'h2D, 64'h7008, 64'h0A0B0C0D_01020304, 5'd0, 0, 0, 32'h0, 32'h0, 1);
        apply_stimulus(6'h08, 64'h1001, 64'h0, 5'd4, 0, 0, 32'h0, 32'h0, -1);
        check_output("lda no bus", obs_adr.size(), 64'd0);

        // Reset asserted between clock edges while the second beat waits for ack.
        set_idle_exp();
        in_valid = 1'b1;
        in_opc   = 6'h29;
        in_adr   = 64'h8000;
        in_dest  = 5'd5;
        step();
        in_valid     = 1'b0;
        exp_in_ready = 1'b0;
        exp_req      = 1'b1;
        exp_adr      = 32'h8000;
        mem_ack      = 1'b1;
        mem_rdata    = 32'h12345678;
        step();
        mem_ack = 1'b0;
        exp_adr = 32'h8004;
        #5;
        set_idle_exp();
        rst_n = 1'b0;
        #1;
        check_output("async rst mem_req", mem_req, 1'b0);
        check_output("async rst in_ready", in_ready, 1'b1);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();

        check_en = 1'b0;
        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
